// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code set 2 constants, protocol FSM encoding and key event payload.
package ps2_pkg;

    localparam int unsigned FRAME_BITS = 11;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Arrow keys (E0-prefixed), also decoded by the game datapath
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       make;
        logic       ext;
    } key_evt_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, 11-bit frame capture, stop/parity check, timeout.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100_000,
    parameter int unsigned TO_W           = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       fsm_busy,
    output logic       byte_strobe,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       timeout_c
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] PAR_BIT = CNT_W'(FRAME_BITS - 2);

    logic [2:0]       clk_sync;
    logic [1:0]       data_sync;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0]       shift_q;
    logic             par_q;
    logic [TO_W-1:0]  to_q;
    logic             fall_c;
    logic             data_c;
    logic             busy_c;
    logic             parity_ok_c;

    // clk_sync[2] is the previous synced ps2_clk, used for falling-edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign fall_c    = clk_sync[2] & ~clk_sync[1];
    assign data_c    = data_sync[1];
    assign busy_c    = (bit_cnt != '0) || fsm_busy;
    assign timeout_c = (to_q == TO_W'(TIMEOUT_CYCLES)) && !fall_c;
    assign byte_data = shift_q;

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok_c = ^{shift_q, par_q};
`else
    logic par_unused;
    assign par_unused  = par_q;
    assign parity_ok_c = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
            if (fall_c) begin
                if (bit_cnt == '0) begin
                    // A high start bit is noise: stay waiting for a real start
                    if (!data_c) bit_cnt <= CNT_W'(1);
                end else if (bit_cnt < PAR_BIT) begin
                    shift_q <= {data_c, shift_q[7:1]};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end else if (bit_cnt == PAR_BIT) begin
                    par_q   <= data_c;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end else begin
                    bit_cnt <= '0;
                    if (!data_c || !parity_ok_c) frame_err   <= 1'b1;
                    else                         byte_strobe <= 1'b1;
                end
            end else if (timeout_c) begin
                bit_cnt <= '0;
            end
        end
    end

    // Abandons partial frames / pending prefixes after a silent bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_q <= '0;
        end else if (fall_c || timeout_c || !busy_c) begin
            to_q <= '0;
        end else begin
            to_q <= to_q + TO_W'(1);
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver top: frame capture plus E0/F0 prefix decode into held key events.
// Optional PS2_PARITY_CHECK_EN enables parity rejection in ps2_frame_rx.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100_000,
    parameter int unsigned TO_W           = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_make,
    output logic       key_ext,
    output logic       key_valid,
    output logic       frame_err
);

    ps2_state_e state_q, state_d;
    key_evt_t   evt_q, evt_d;
    logic       emit_c;
    logic       byte_strobe;
    logic [7:0] byte_data;
    logic       timeout_c;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_frame (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .fsm_busy   (state_q != S_IDLE),
        .byte_strobe(byte_strobe),
        .byte_data  (byte_data),
        .frame_err  (frame_err),
        .timeout_c  (timeout_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Prefix decoder: E0 marks extended, F0 marks break; any other byte completes a key event
    always_comb begin
        state_d   = state_q;
        emit_c    = 1'b0;
        evt_d     = evt_q;
        if (frame_err || timeout_c) begin
            state_d = S_IDLE;
        end else if (byte_strobe) begin
            evt_d.code = byte_data;
            case (state_q)
                S_IDLE: begin
                    if (byte_data == SC_EXT)      state_d = S_EXT;
                    else if (byte_data == SC_BRK) state_d = S_BRK;
                    else begin
                        emit_c = 1'b1; evt_d.make = 1'b1; evt_d.ext = 1'b0;
                    end
                end
                S_EXT: begin
                    if (byte_data == SC_BRK)      state_d = S_EXT_BRK;
                    else if (byte_data != SC_EXT) begin
                        emit_c = 1'b1; evt_d.make = 1'b1; evt_d.ext = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_BRK: begin
                    if (byte_data == SC_EXT)      state_d = S_EXT_BRK;
                    else if (byte_data != SC_BRK) begin
                        emit_c = 1'b1; evt_d.make = 1'b0; evt_d.ext = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                S_EXT_BRK: begin
                    if (byte_data != SC_EXT && byte_data != SC_BRK) begin
                        emit_c = 1'b1; evt_d.make = 1'b0; evt_d.ext = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_q     <= '0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= emit_c;
            if (emit_c) evt_q <= evt_d;
        end
    end

    assign keycode  = evt_q.code;
    assign key_make = evt_q.make;
    assign key_ext  = evt_q.ext;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx with a scaled PS/2 bit rate and timeout.
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int unsigned HALF    = 40;
    localparam int unsigned TO_CYC  = 2000;
    localparam int unsigned TO_BITS = 11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       key_make, key_ext, key_valid, frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stop_cyc = 0;
    int kv_cnt = 0;
    int ferr_cnt = 0;
    int exp_ferr = 0;
    key_evt_t exp_q[$];

    ps2_keyboard_rx #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(TO_BITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .keycode  (keycode),
        .key_make (key_make),
        .key_ext  (key_ext),
        .key_valid(key_valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] code, input logic make, input logic ext);
        key_evt_t e;
        e.code = code; e.make = make; e.ext = ext;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives nbits of an 11-bit frame; parity/stop can be corrupted
    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = ~(^b) ^ bad_par;
        f[10]  = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic send_full(input logic [7:0] b);
        send(b, 1'b0, 1'b0, 11);
    endtask

    // Monitor: every key_valid pops one expected event and checks it plus its latency
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) ferr_cnt++;
            if (key_valid) begin
                kv_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_key_valid", {24'h0, keycode}, 32'hFFFF_FFFF);
                end else begin
                    key_evt_t e;
                    e = exp_q.pop_front();
                    chk("keycode", {24'h0, keycode}, {24'h0, e.code});
                    chk("key_make", {31'h0, key_make}, {31'h0, e.make});
                    chk("key_ext", {31'h0, key_ext}, {31'h0, e.ext});
                    chk("latency", cyc - stop_cyc, 32'd4);
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_keycode"}, {24'h0, keycode}, 32'h0);
        chk({tag, "_make"}, {31'h0, key_make}, 32'h0);
        chk({tag, "_ext"}, {31'h0, key_ext}, 32'h0);
        chk({tag, "_valid"}, {31'h0, key_valid}, 32'h0);
        chk({tag, "_ferr"}, {31'h0, frame_err}, 32'h0);
    endtask

    initial begin
        int kv0;
        wait_cyc(3);
        chk_reset_outputs("reset");
        reset = 1'b0;
        wait_cyc(5);

        // Extended make with hold check
        push(KEY_UP, 1'b1, 1'b1);
        send_full(SC_EXT);
        send_full(KEY_UP);
        kv0 = kv_cnt;
        wait_cyc(1000);
        chk("hold_keycode", {24'h0, keycode}, 32'h75);
        chk("hold_make", {31'h0, key_make}, 32'h1);
        chk("hold_ext", {31'h0, key_ext}, 32'h1);
        chk("hold_no_pulse", kv_cnt - kv0, 32'd0);

        // Extended break, then plain make
        push(KEY_LEFT, 1'b0, 1'b1);
        push(8'h1C, 1'b1, 1'b0);
        send_full(SC_EXT);
        send_full(SC_BRK);
        send_full(KEY_LEFT);
        send_full(8'h1C);

        // Plain break: prefix frame must not pulse
        kv0 = kv_cnt;
        push(8'h1C, 1'b0, 1'b0);
        send_full(SC_BRK);
        chk("prefix_no_pulse", kv_cnt - kv0, 32'd0);
        send_full(8'h1C);
        chk("brk_one_pulse", kv_cnt - kv0, 32'd1);

        // Bad parity on 72
`ifdef PS2_PARITY_CHECK_EN
        exp_ferr++;
`else
        push(KEY_DOWN, 1'b1, 1'b0);
`endif
        send(KEY_DOWN, 1'b1, 1'b0, 11);
        push(KEY_DOWN, 1'b1, 1'b1);
        send_full(SC_EXT);
        send_full(KEY_DOWN);
        chk("parity_ferr_cnt", ferr_cnt, exp_ferr);

        // Bad stop bit: frame_err, no byte
        kv0 = kv_cnt;
        exp_ferr++;
        send(8'h1C, 1'b0, 1'b1, 11);
        chk("stop_ferr_cnt", ferr_cnt, exp_ferr);
        chk("stop_no_pulse", kv_cnt - kv0, 32'd0);
        push(KEY_RIGHT, 1'b1, 1'b0);
        send_full(KEY_RIGHT);

        // Pending E0 abandoned by timeout
        send_full(SC_EXT);
        wait_cyc(TO_CYC + 1);
        push(KEY_RIGHT, 1'b1, 1'b0);
        send_full(KEY_RIGHT);
        chk("timeout_no_ferr", ferr_cnt, exp_ferr);

        // Partial frame abandoned by timeout
        kv0 = kv_cnt;
        send(8'h33, 1'b0, 1'b0, 5);
        wait_cyc(TO_CYC * 21 / 20);
        push(KEY_UP, 1'b1, 1'b0);
        send_full(KEY_UP);
        chk("partial_one_pulse", kv_cnt - kv0, 32'd1);

        // Reset during bit 6 of a frame
        send(8'hA5, 1'b0, 1'b0, 6);
        reset = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        wait_cyc(10);
        chk_reset_outputs("midrst_hold");
        reset = 1'b0;
        wait_cyc(5);
        kv0 = kv_cnt;
        push(KEY_UP, 1'b1, 1'b1);
        send_full(SC_EXT);
        send_full(KEY_UP);
        wait_cyc(20);
        chk("post_reset_one_pulse", kv_cnt - kv0, 32'd1);

        chk("queue_empty", exp_q.size(), 32'd0);
        chk("final_ferr_cnt", ferr_cnt, exp_ferr);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
